pipeline_stall_ctrl: RTL

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

---
 rtl/pipeline_pkg.sv | 27 ++
 rtl/pipeline_stall_ctrl_sat_counter.sv | 35 +++
 rtl/pipeline_stall_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline stall controller.
// State encoding, control bundle and default counter width.
package pipeline_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    HOLD       = 2'd1,
    HOLD_REDIR = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic pc_redirect;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic pipe_write;
  } ctrl_t;

  localparam ctrl_t CTRL_FREEZE = 6'b000000;
  localparam ctrl_t CTRL_RUN    = 6'b101001;
  localparam ctrl_t CTRL_HAZ    = 6'b000011;
  localparam ctrl_t CTRL_REDIR  = 6'b111101;

endpackage

// File: rtl/pipeline_stall_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline stall/flush controller with cache-freeze FSM.
// Drives PC, IF/ID and downstream enables plus perf counters.
module pipeline_stall_ctrl
  import pipeline_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hazard_stall,
  input  logic             redirect,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             pc_redirect,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_write,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;
  logic   cache_stall;

  always_comb begin
    cache_stall = icache_stall | dcache_stall;
    state_d     = state_q;
    ctrl        = CTRL_RUN;
    if (state_q == HOLD_REDIR) begin
      // ID is frozen, so the captured redirect is replayed on release
      if (cache_stall) begin
        ctrl = CTRL_FREEZE;
      end else begin
        ctrl    = CTRL_REDIR;
        state_d = RUN;
      end
    end else if (cache_stall) begin
      ctrl    = CTRL_FREEZE;
      state_d = (redirect && !hazard_stall) ? HOLD_REDIR : HOLD;
    end else begin
      state_d = RUN;
      if (hazard_stall) begin
        ctrl = CTRL_HAZ;
      end else if (redirect) begin
        ctrl = CTRL_REDIR;
      end
    end
    if (!rst_n) begin
      ctrl = CTRL_FREEZE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  assign pc_write    = ctrl.pc_write;
  assign pc_redirect = ctrl.pc_redirect;
  assign ifid_write  = ctrl.ifid_write;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_bubble = ctrl.idex_bubble;
  assign pipe_write  = ctrl.pipe_write;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!ctrl.pc_write),
    .clr   (cnt_clr),
    .cnt   (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ctrl.ifid_flush),
    .clr   (cnt_clr),
    .cnt   (flush_count)
  );

endmodule
